imuldiv_muldiv_requester: RTL and testbench
===========================================

IMULDIV_MULDIV_REQUESTER -- requirements
Module: imuldiv_muldiv_requester

Interface
REQ-001 SHALL have parameter DEPTH, default 2, max outstanding requests (power of two, 2..8).
REQ-002 SHALL have parameter TAGW, default 5, width of destination-register tag.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports cmd_val in 1, cmd_rdy out 1, cmd_fn in 3, cmd_a in 32, cmd_b in 32, cmd_tag in TAGW: pipeline-side command.
REQ-006 SHALL have ports muldivreq_msg_fn out 3, muldivreq_msg_a out 32, muldivreq_msg_b out 32, muldivreq_val out 1, muldivreq_rdy in 1: request to the muldiv unit.
REQ-007 SHALL have ports muldivresp_msg_result in 64, muldivresp_val in 1, muldivresp_rdy out 1: response from the muldiv unit.
REQ-008 SHALL have ports wb_val out 1, wb_rdy in 1, wb_tag out TAGW, wb_data out 32: writeback result.
REQ-009 SHALL have port err out 1, sticky protocol-error flag.

Function
REQ-010 SHALL encode fn: 0 mul, 1 div, 2 divu, 3 rem, 4 remu; fn 5..7 reserved.
REQ-011 SHALL drive muldivreq_msg_fn/a/b combinationally from cmd_fn/a/b.
REQ-012 SHALL drive muldivreq_val = cmd_val & !full and cmd_rdy = muldivreq_rdy & !full; full = (count == DEPTH) at cycle start, no same-cycle pop bypass.
REQ-013 SHALL push {cmd_tag, word-select} into an in-order tag FIFO on each cmd fire (cmd_val & cmd_rdy).
REQ-014 SHALL set word-select = high for fn 3/4 (result[63:32]), low for fn 0/1/2 (result[31:0]); reserved fn selects low.
REQ-015 SHALL drive muldivresp_rdy = !empty & (!wb_val | wb_rdy).
REQ-016 SHALL, on response fire, pop FIFO head, load output register with head tag and selected 32-bit word, assert wb_val next cycle (1-cycle latency).
REQ-017 SHALL hold wb_val/wb_tag/wb_data stable while wb_val & !wb_rdy; clear wb_val after wb fire unless reloaded same cycle.
REQ-018 SHALL allow push and pop in the same cycle; count unchanged, pointers wrap modulo DEPTH.
REQ-019 SHALL set err when muldivresp_val & empty; err clears only on reset.
REQ-020 SHALL preserve order: wb results emerge in command-fire order.

Reset
REQ-021 SHALL on reset clear count, read/write pointers, wb_val, err; wb_tag and wb_data reset to 0.
REQ-022 SHALL on reset mid-operation discard all outstanding tags; muldiv unit SHALL share the same reset.
REQ-023 SHALL during reset hold cmd_rdy, muldivreq_val, muldivresp_rdy, wb_val at 0.

Configuration
REQ-024 SHALL, with IMULDIV_REQUESTER_PERF_EN defined, add outputs perf_issued (32b, +1 per cmd fire), perf_retired (32b, +1 per wb fire), perf_stall (32b, +1 per cycle cmd_val & !cmd_rdy); all reset to 0, wrap at 2^32.
REQ-025 SHALL, without IMULDIV_REQUESTER_PERF_EN, omit those ports and counters entirely; other behaviour identical.

Structure
REQ-026 SHALL place fn encodings, word-select constants and result-slice widths in shared package imuldiv_MulDivReqMsg definitions.
REQ-027 SHALL implement the tag FIFO as sub-module imuldiv_TagQueue (parameterised DEPTH, width TAGW+1, with full/empty).

Verification
REQ-028 SHALL test mul 0xfffffff8 x 0x00000008, tag 3 -> wb_tag 3, wb_data 0xffffffc0.
REQ-029 SHALL test rem 0xfffffff9, 0x00000003, tag 7 -> wb_data 0xffffffff; divu 0xffffffff, 2, tag 9 -> wb_data 0x7fffffff, in order.
REQ-030 SHALL test DEPTH=2 with muldivresp stalled: third cmd sees cmd_rdy 0 until one response fires; perf_stall increments per stalled cycle (PERF_EN build).
REQ-031 SHALL test wb_rdy held 0 for 5 cycles: wb_val/wb_tag/wb_data stable, muldivresp_rdy 0, no result lost after release.
REQ-032 SHALL test injected muldivresp_val with empty FIFO -> err 1 next cycle and sticky until reset.
REQ-033 SHALL test reset asserted with 2 outstanding: after release wb_val 0, count 0, next cmd mul 1x1 -> wb_data 0x00000001.

Source files
------------

// File: rtl/imuldiv_muldiv_requester_pkg.sv
// Shared muldiv request/response message definitions.
// Covers function encodings, word-select values and result slice widths.
package imuldiv_MulDivReqMsg;

  localparam int unsigned FN_W     = 3;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned RESULT_W = 64;

  typedef enum logic [FN_W-1:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4
  } muldiv_fn_e;

  // The muldiv unit returns {remainder, quotient} or the full product.
  localparam logic WSEL_LO = 1'b0;
  localparam logic WSEL_HI = 1'b1;

  // Remainder ops take the upper word. Every other code, including the
  // reserved ones, takes the lower word.
  function automatic logic fn_wsel(input logic [FN_W-1:0] fn);
    logic sel;
    sel = WSEL_LO;
    if (fn == FN_REM || fn == FN_REMU) sel = WSEL_HI;
    return sel;
  endfunction

  function automatic logic [WORD_W-1:0] select_word(input logic [RESULT_W-1:0] result,
                                                     input logic wsel);
    logic [WORD_W-1:0] word;
    word = result[WORD_W-1:0];
    if (wsel == WSEL_HI) word = result[RESULT_W-1:WORD_W];
    return word;
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_requester_tagqueue.sv
// In-order tag FIFO for outstanding muldiv requests.
// DEPTH must be a power of two, so the pointers wrap naturally.
module imuldiv_TagQueue #(
  parameter int DEPTH = 2,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy tracking. A simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset. Entries are only read after they are written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/imuldiv_muldiv_requester.sv
// Muldiv requester: forwards pipeline commands to the muldiv unit.
// It remembers each destination tag and word select in order, and returns
// the selected result word through a one-entry writeback register.
// Optional build macro: IMULDIV_REQUESTER_PERF_EN adds the perf counter outputs.
module imuldiv_muldiv_requester
  import imuldiv_MulDivReqMsg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAGW  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_val,
  output logic                cmd_rdy,
  input  logic [FN_W-1:0]     cmd_fn,
  input  logic [WORD_W-1:0]   cmd_a,
  input  logic [WORD_W-1:0]   cmd_b,
  input  logic [TAGW-1:0]     cmd_tag,
  output logic [FN_W-1:0]     muldivreq_msg_fn,
  output logic [WORD_W-1:0]   muldivreq_msg_a,
  output logic [WORD_W-1:0]   muldivreq_msg_b,
  output logic                muldivreq_val,
  input  logic                muldivreq_rdy,
  input  logic [RESULT_W-1:0] muldivresp_msg_result,
  input  logic                muldivresp_val,
  output logic                muldivresp_rdy,
  output logic                wb_val,
  input  logic                wb_rdy,
  output logic [TAGW-1:0]     wb_tag,
  output logic [WORD_W-1:0]   wb_data,
  output logic                err
`ifdef IMULDIV_REQUESTER_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_retired,
  output logic [31:0]         perf_stall
`endif
);

  logic          full;
  logic          empty;
  logic [TAGW:0] head;
  logic          cmd_fire;
  logic          resp_fire;
  logic          wb_fire;
  logic          wb_val_q;

  assign muldivreq_msg_fn = cmd_fn;
  assign muldivreq_msg_a  = cmd_a;
  assign muldivreq_msg_b  = cmd_b;

  // The handshakes are gated by reset so nothing leaks out before the first edge.
  // Full is the state at the start of the cycle. A pop in the same cycle does not free the slot.
  assign muldivreq_val  = cmd_val & ~full & ~reset;
  assign cmd_rdy        = muldivreq_rdy & ~full & ~reset;
  assign muldivresp_rdy = ~empty & (~wb_val_q | wb_rdy) & ~reset;
  assign wb_val         = wb_val_q & ~reset;

  assign cmd_fire  = cmd_val & cmd_rdy;
  assign resp_fire = muldivresp_val & muldivresp_rdy;
  assign wb_fire   = wb_val & wb_rdy;

  imuldiv_TagQueue #(
    .DEPTH (DEPTH),
    .W     (TAGW + 1)
  ) u_tag_queue (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_fire),
    .pop   (resp_fire),
    .din   ({cmd_tag, fn_wsel(cmd_fn)}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Writeback register: loads on response fire and holds until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_val_q <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
    end else if (resp_fire) begin
      wb_val_q <= 1'b1;
      wb_tag   <= head[TAGW:1];
      wb_data  <= select_word(muldivresp_msg_result, head[0]);
    end else if (wb_fire) begin
      wb_val_q <= 1'b0;
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset)                        err <= 1'b0;
    else if (muldivresp_val & empty)  err <= 1'b1;
  end

`ifdef IMULDIV_REQUESTER_PERF_EN
  // Free-running event counters. They wrap at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued  <= '0;
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (cmd_fire)            perf_issued  <= perf_issued + 32'd1;
      if (wb_fire)             perf_retired <= perf_retired + 32'd1;
      if (cmd_val & ~cmd_rdy)  perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imuldiv_muldiv_requester.sv
// Randomised and directed bench for imuldiv_muldiv_requester.
module tb_imuldiv_muldiv_requester;

  localparam int DEPTH = 2;
  localparam int TAGW  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [2:0]  cmd_fn;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [4:0]  cmd_tag;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  logic        wb_val;
  logic        wb_rdy;
  logic [4:0]  wb_tag;
  logic [31:0] wb_data;
  logic        err;
`ifdef IMULDIV_REQUESTER_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;
`endif

  imuldiv_muldiv_requester #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_val               (cmd_val),
    .cmd_rdy               (cmd_rdy),
    .cmd_fn                (cmd_fn),
    .cmd_a                 (cmd_a),
    .cmd_b                 (cmd_b),
    .cmd_tag               (cmd_tag),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .wb_val                (wb_val),
    .wb_rdy                (wb_rdy),
    .wb_tag                (wb_tag),
    .wb_data               (wb_data),
    .err                   (err)
`ifdef IMULDIV_REQUESTER_PERF_EN
    ,
    .perf_issued           (perf_issued),
    .perf_retired          (perf_retired),
    .perf_stall            (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
  } wb_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state: writebacks owed by the DUT, results held by the
  // external unit, the writeback slot, the sticky error and the event counts.
  wb_t         pend_q[$];
  logic [63:0] unit_q[$];
  wb_t         wb_log[$];
  bit          m_wb_valid = 0;
  wb_t         m_wb;
  bit          m_err = 0;
  int unsigned m_issued = 0;
  int unsigned m_retired = 0;
  int unsigned m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic result the pipeline should see for each function code.
  function automatic logic [31:0] ref_wb_data(input logic [2:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (fn)
      3'd0:    return a * b;
      3'd1:    return 32'(sa / sb);
      3'd2:    return a / b;
      3'd3:    return 32'(sa % sb);
      3'd4:    return a % b;
      default: return a;
    endcase
  endfunction

  // Behaviour of the external muldiv unit: {remainder, quotient} or the full product.
  function automatic logic [63:0] unit_result(input logic [2:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (fn)
      3'd0:      return {32'h0, a} * {32'h0, b};
      3'd1, 3'd3: begin q = 32'(sa / sb); r = 32'(sa % sb); return {r, q}; end
      3'd2, 3'd4: return {a % b, a / b};
      default:   return {b, a};
    endcase
  endfunction

  task automatic cycle(input bit cv, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input bit rq_rdy,
                       input bit resp_en, input bit inject, input bit wrdy);
    int  n_out;
    bit  e_full;
    bit  e_empty;
    bit  e_cmd_rdy;
    bit  e_resp_rdy;
    wb_t e;
    @(negedge clk);
    cmd_val       = cv;
    cmd_fn        = fn;
    cmd_a         = a;
    cmd_b         = b;
    cmd_tag       = tag;
    muldivreq_rdy = rq_rdy;
    wb_rdy        = wrdy;
    if (inject) begin
      muldivresp_val        = 1'b1;
      muldivresp_msg_result = {$urandom, $urandom};
    end else if (resp_en && unit_q.size() > 0) begin
      muldivresp_val        = 1'b1;
      muldivresp_msg_result = unit_q[0];
    end else begin
      muldivresp_val        = 1'b0;
      muldivresp_msg_result = {$urandom, $urandom};
    end
    #1;
    n_out      = pend_q.size();
    e_full     = (n_out >= DEPTH);
    e_empty    = (n_out == 0);
    e_cmd_rdy  = rq_rdy && !e_full;
    e_resp_rdy = !e_empty && (!m_wb_valid || wrdy);

    chk("err", err, m_err);
    chk("wb_val", wb_val, m_wb_valid);
    if (m_wb_valid) begin
      chk("wb_tag", wb_tag, m_wb.tag);
      chk("wb_data", wb_data, m_wb.data);
    end
    chk("cmd_rdy", cmd_rdy, e_cmd_rdy);
    chk("muldivreq_val", muldivreq_val, cv && !e_full);
    chk("muldivresp_rdy", muldivresp_rdy, e_resp_rdy);
    if (cv) begin
      chk("req_ab", {muldivreq_msg_a, muldivreq_msg_b}, {a, b});
      chk("req_fn", muldivreq_msg_fn, fn);
    end

    if (m_wb_valid && wrdy) begin
      wb_log.push_back(m_wb);
      m_wb_valid = 0;
      m_retired++;
    end
    if (muldivresp_val && e_empty) m_err = 1;
    if (muldivresp_val && e_resp_rdy) begin
      m_wb       = pend_q.pop_front();
      m_wb_valid = 1;
      unit_q.delete(0);
    end
    if (cv && e_cmd_rdy) begin
      e.tag  = tag;
      e.data = ref_wb_data(fn, a, b);
      pend_q.push_back(e);
      unit_q.push_back(unit_result(fn, a, b));
      m_issued++;
    end
    if (cv && !e_cmd_rdy) m_stall++;
  endtask

  task automatic idle(input bit resp_en, input bit wrdy);
    cycle(0, 3'd0, 32'd0, 32'd1, 5'd0, 1, resp_en, 0, wrdy);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (pend_q.size() > 0 || m_wb_valid); i++) idle(1, 1);
    chk(tag, pend_q.size() + int'(m_wb_valid), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset          = 1'b1;
    cmd_val        = 1'b1;
    muldivreq_rdy  = 1'b1;
    muldivresp_val = 1'b0;
    wb_rdy         = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_req_val", muldivreq_val, 0);
      chk("rst_resp_rdy", muldivresp_rdy, 0);
      chk("rst_wb_val", wb_val, 0);
      chk("rst_err", err, 0);
      chk("rst_wb_tag", wb_tag, 0);
      chk("rst_wb_data", wb_data, 0);
`ifdef IMULDIV_REQUESTER_PERF_EN
      chk("rst_perf", {perf_issued, perf_stall}, 0);
      chk("rst_perf_ret", perf_retired, 0);
`endif
    end
    reset   = 1'b0;
    cmd_val = 1'b0;
    pend_q.delete();
    unit_q.delete();
    m_wb_valid = 0;
    m_err      = 0;
    m_issued   = 0;
    m_retired  = 0;
    m_stall    = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  blocked;
    bit  fired;
    int unsigned iss0;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    cmd_val = 0; cmd_fn = 0; cmd_a = 0; cmd_b = 0; cmd_tag = 0;
    muldivreq_rdy = 0; muldivresp_val = 0; muldivresp_msg_result = 0; wb_rdy = 0;
    do_reset(2);

    // mul with a negative operand: low word of the product
    wb_log.delete();
    cycle(1, 3'd0, 32'hfffffff8, 32'h00000008, 5'd3, 1, 0, 0, 1);
    drain("drain_mul");
    chk("mul_count", wb_log.size(), 1);
    chk("mul_tag", wb_log[0].tag, 5'd3);
    chk("mul_data", wb_log[0].data, 32'hffffffc0);

    // rem then divu, which must retire in order
    wb_log.delete();
    cycle(1, 3'd3, 32'hfffffff9, 32'h00000003, 5'd7, 1, 0, 0, 1);
    cycle(1, 3'd2, 32'hffffffff, 32'h00000002, 5'd9, 1, 0, 0, 1);
    drain("drain_remdivu");
    chk("rd_count", wb_log.size(), 2);
    chk("rem_tag", wb_log[0].tag, 5'd7);
    chk("rem_data", wb_log[0].data, 32'hffffffff);
    chk("divu_tag", wb_log[1].tag, 5'd9);
    chk("divu_data", wb_log[1].data, 32'h7fffffff);

    // Fill to DEPTH with responses stalled. The third command waits, including the
    // cycle in which a response fires, because there is no same-cycle bypass.
    wb_log.delete();
    cycle(1, 3'd0, 32'd5, 32'd6, 5'd10, 1, 0, 0, 1);
    cycle(1, 3'd4, 32'd17, 32'd5, 5'd11, 1, 0, 0, 1);
    blocked = 0;
    fired   = 0;
    for (int i = 0; i < 12 && !fired; i++) begin
      iss0 = m_issued;
      cycle(1, 3'd1, 32'hffffff9c, 32'd7, 5'd12, 1, (i >= 4), 0, 1);
      if (m_issued != iss0) fired = 1;
      else blocked++;
    end
    chk("third_fired", fired, 1);
    chk("third_blocked", blocked, 5);
`ifdef IMULDIV_REQUESTER_PERF_EN
    chk("perf_stall_depth", perf_stall, m_stall);
`endif
    drain("drain_depth");
    chk("depth_order", {wb_log[0].tag, wb_log[1].tag, wb_log[2].tag}, {5'd10, 5'd11, 5'd12});
    chk("depth_div", wb_log[2].data, 32'hfffffff2);

    // writeback backpressure for 5 cycles
    wb_log.delete();
    cycle(1, 3'd0, 32'd3, 32'd4, 5'd20, 1, 0, 0, 0);
    cycle(1, 3'd3, 32'd13, 32'd4, 5'd21, 1, 0, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 5; i++) idle(1, 0);
    chk("bp_resp_rdy", muldivresp_rdy, 0);
    drain("drain_bp");
    chk("bp_count", wb_log.size(), 2);
    chk("bp_first", {wb_log[0].tag, wb_log[0].data}, {5'd20, 32'd12});
    chk("bp_second", {wb_log[1].tag, wb_log[1].data}, {5'd21, 32'd1});

    // response with nothing outstanding sets the sticky error
    cycle(0, 3'd0, 32'd0, 32'd1, 5'd0, 1, 0, 1, 1);
    idle(0, 1);
    chk("err_set", err, 1);
    cycle(1, 3'd0, 32'd2, 32'd2, 5'd1, 1, 0, 0, 1);
    drain("drain_err");
    chk("err_sticky", err, 1);

    // reset with two requests outstanding discards them
    cycle(1, 3'd0, 32'd9, 32'd9, 5'd2, 1, 0, 0, 1);
    cycle(1, 3'd0, 32'd8, 32'd8, 5'd3, 1, 0, 0, 1);
    do_reset(2);
    idle(0, 1);
    chk("post_rst_wb_val", wb_val, 0);
    chk("post_rst_cmd_rdy", cmd_rdy, 1);
    wb_log.delete();
    cycle(1, 3'd0, 32'd1, 32'd1, 5'd4, 1, 0, 0, 1);
    drain("drain_post_rst");
    chk("post_rst_mul", {wb_log.size(), wb_log[0].data}, {32'd1, 32'h00000001});

    // random traffic
    wb_log.delete();
    iss0 = m_issued;
    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
      if (rb == 0) rb = 1;
      if (ra == 32'h80000000 && rb == 32'hffffffff) rb = 1;
      cycle($urandom_range(0, 1), 3'($urandom_range(0, 7)), ra, rb, 5'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 3), 0,
            ($urandom_range(0, 9) < 7));
    end
    drain("drain_random");
    chk("random_count", wb_log.size(), m_issued - iss0);
`ifdef IMULDIV_REQUESTER_PERF_EN
    chk("perf_issued", perf_issued, m_issued);
    chk("perf_retired", perf_retired, m_retired);
    chk("perf_stall", perf_stall, m_stall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
